// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath constants: widths, write-back selects and load funct3 codes.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned CNTW = 2;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_NONE = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the byte/halfword out of the raw dmem word and extends it.
module load_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Lane select followed by extension; unknown funct3 is reported as misaligned.
  always_comb begin
    byte_val   = word[7:0];
    half_val   = offset[1] ? word[31:16] : word[15:0];
    data       = word;
    misaligned = 1'b0;
    case (offset)
      2'd0:    byte_val = word[7:0];
      2'd1:    byte_val = word[15:8];
      2'd2:    byte_val = word[23:16];
      default: byte_val = word[31:24];
    endcase
    case (funct3)
      F3_LB:   data = {{24{byte_val[7]}}, byte_val};
      F3_LBU:  data = {24'd0, byte_val};
      F3_LH: begin
        data       = {{16{half_val[15]}}, half_val};
        misaligned = offset[0];
      end
      F3_LHU: begin
        data       = {16'd0, half_val};
        misaligned = offset[0];
      end
      F3_LW:   misaligned = (offset != 2'd0);
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/reg_writeback.sv
// MEM/WB register stage driving the regfile write port, plus the pending-write scoreboard.
module reg_writeback
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_valid,
  input  logic            mem_reg_we,
  input  logic [4:0]      mem_rd,
  input  logic [1:0]      mem_wb_sel,
  input  logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_load_word,
  input  logic [XLEN-1:0] mem_pc,
  input  logic            id_issue,
  input  logic            id_rd_we,
  input  logic [4:0]      id_rd,
  output logic [4:0]      addr_rd,
  output logic [XLEN-1:0] data_rd,
  output logic            write_enable,
  output logic [NREG-1:0] busy_mask,
  output logic            rd_full,
  output logic            load_misaligned,
  output logic            sb_error
);

  localparam logic [CNTW-1:0] CntMax = '1;

  logic [XLEN-1:0] load_data;
  logic            load_mis;

  load_align u_load_align (
    .word       (mem_load_word),
    .offset     (mem_alu_result[1:0]),
    .funct3     (mem_funct3),
    .data       (load_data),
    .misaligned (load_mis)
  );

  logic            retire;
  logic            is_load;
  logic            mis_hit;
  logic            wr_en;
  logic [XLEN-1:0] wb_data;

  // Retire qualification and write-back data select for the slot being captured.
  always_comb begin
    retire  = mem_valid & mem_reg_we & (mem_rd != 5'd0);
    is_load = (mem_wb_sel == WB_SEL_LOAD);
    mis_hit = mem_valid & mem_reg_we & is_load & load_mis;
    wr_en   = retire & (mem_wb_sel != WB_SEL_NONE) & ~(is_load & load_mis);
    case (mem_wb_sel)
      WB_SEL_LOAD: wb_data = load_data;
      WB_SEL_PC4:  wb_data = mem_pc + 32'd4;
      default:     wb_data = mem_alu_result;
    endcase
  end

  // Retire captured at edge N frees its scoreboard slot at edge N+1, with the regfile write.
  logic            dec_q;
  logic [4:0]      dec_rd_q;
  logic [CNTW-1:0] cnt_q [NREG];
  logic [CNTW-1:0] cnt_d [NREG];
  logic [NREG-1:0] inc_vec;
  logic [NREG-1:0] dec_vec;
  logic            err;

  // Per-register counter next state; simultaneous inc and dec cancel out.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    err     = 1'b0;
    if (id_issue && id_rd_we && (id_rd != 5'd0)) inc_vec[id_rd] = 1'b1;
    if (dec_q) dec_vec[dec_rd_q] = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_vec[i] && !dec_vec[i]) begin
        if (cnt_q[i] == CntMax) err = 1'b1;
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec_vec[i] && !inc_vec[i]) begin
        if (cnt_q[i] == '0) err = 1'b1;
        else cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  // Decode-facing scoreboard views.
  always_comb begin
    busy_mask = '0;
    for (int i = 1; i < NREG; i++) busy_mask[i] = (cnt_q[i] != '0);
    rd_full = (cnt_q[id_rd] == CntMax) & (id_rd != 5'd0);
  end

  // WB stage registers and scoreboard state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_rd         <= '0;
      data_rd         <= '0;
      write_enable    <= 1'b0;
      load_misaligned <= 1'b0;
      sb_error        <= 1'b0;
      dec_q           <= 1'b0;
      dec_rd_q        <= '0;
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
    end else begin
      write_enable    <= wr_en;
      load_misaligned <= mis_hit;
      if (wr_en) begin
        addr_rd <= mem_rd;
        data_rd <= wb_data;
      end
      dec_q    <= retire;
      dec_rd_q <= mem_rd;
      sb_error <= sb_error | err;
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed cases plus randomized traffic vs a model.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_reg_we;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result, mem_load_word, mem_pc;
  logic        id_issue, id_rd_we;
  logic [4:0]  id_rd;
  logic [4:0]  addr_rd;
  logic [31:0] data_rd;
  logic        write_enable;
  logic [31:0] busy_mask;
  logic        rd_full, load_misaligned, sb_error;

  reg_writeback dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_valid       (mem_valid),
    .mem_reg_we      (mem_reg_we),
    .mem_rd          (mem_rd),
    .mem_wb_sel      (mem_wb_sel),
    .mem_funct3      (mem_funct3),
    .mem_alu_result  (mem_alu_result),
    .mem_load_word   (mem_load_word),
    .mem_pc          (mem_pc),
    .id_issue        (id_issue),
    .id_rd_we        (id_rd_we),
    .id_rd           (id_rd),
    .addr_rd         (addr_rd),
    .data_rd         (data_rd),
    .write_enable    (write_enable),
    .busy_mask       (busy_mask),
    .rd_full         (rd_full),
    .load_misaligned (load_misaligned),
    .sb_error        (sb_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Reference model state: pending-write counts, expected port values, retire awaiting commit.
  int          m_cnt [32];
  bit          m_err, m_we, m_mis, m_ret;
  logic [4:0]  m_addr, m_ret_rd;
  logic [31:0] m_data;
  logic [31:0] exp_busy;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model_load(input logic [31:0] w, input logic [1:0] off,
                                     input logic [2:0] f3, output logic [31:0] v,
                                     output bit mis);
    logic [7:0]  b;
    logic [15:0] h;
    b   = 8'(w >> (8 * off));
    h   = 16'(w >> (16 * off[1]));
    mis = 1'b0;
    v   = w;
    case (f3)
      3'b000:  v = 32'($signed(b));
      3'b100:  v = {24'd0, b};
      3'b001:  begin mis = off[0]; v = 32'($signed(h)); end
      3'b101:  begin mis = off[0]; v = {16'd0, h}; end
      3'b010:  mis = (off != 2'd0);
      default: mis = 1'b1;
    endcase
  endfunction

  // Advance the model by one rising edge using the inputs held across that edge.
  task automatic model_step();
    logic [31:0] val;
    bit          mis;
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_err = 0; m_we = 0; m_mis = 0; m_ret = 0; m_addr = '0; m_ret_rd = '0; m_data = '0;
      return;
    end
    for (int r = 1; r < 32; r++) begin
      int d;
      d = ((id_issue && id_rd_we && id_rd == 5'(r)) ? 1 : 0)
        - ((m_ret && m_ret_rd == 5'(r)) ? 1 : 0);
      if (d > 0) begin
        if (m_cnt[r] == 3) m_err = 1; else m_cnt[r]++;
      end else if (d < 0) begin
        if (m_cnt[r] == 0) m_err = 1; else m_cnt[r]--;
      end
    end
    model_load(mem_load_word, mem_alu_result[1:0], mem_funct3, val, mis);
    if (mem_wb_sel == 2'd0) val = mem_alu_result;
    else if (mem_wb_sel == 2'd2) val = mem_pc + 32'd4;
    if (mem_wb_sel != 2'd1) mis = 0;
    m_we  = mem_valid && mem_reg_we && mem_rd != 0 && mem_wb_sel != 2'd3 && !mis;
    m_mis = mem_valid && mem_reg_we && mis;
    if (m_we) begin
      m_addr = mem_rd;
      m_data = val;
    end
    m_ret    = mem_valid && mem_reg_we && mem_rd != 0;
    m_ret_rd = mem_rd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    mem_valid = 0; mem_reg_we = 0; mem_rd = '0; mem_wb_sel = '0; mem_funct3 = '0;
    mem_alu_result = '0; mem_load_word = '0; mem_pc = '0;
    id_issue = 0; id_rd_we = 0; id_rd = '0;
  endtask

  // MEM slot for rd, issued at the same edge so the scoreboard never underflows.
  task automatic mem_op(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] word, input logic [31:0] pc);
    mem_valid = 1; mem_reg_we = 1; mem_rd = rd; mem_wb_sel = sel; mem_funct3 = f3;
    mem_alu_result = alu; mem_load_word = word; mem_pc = pc;
    id_issue = 1; id_rd_we = 1; id_rd = rd;
    tick();
    idle();
    #1;
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      exp_busy = '0;
      for (int r = 1; r < 32; r++) exp_busy[r] = (m_cnt[r] != 0);
      check("write_enable", {31'd0, write_enable}, {31'd0, m_we});
      check("addr_rd", {27'd0, addr_rd}, {27'd0, m_addr});
      check("data_rd", data_rd, m_data);
      check("load_misaligned", {31'd0, load_misaligned}, {31'd0, m_mis});
      check("busy_mask", busy_mask, exp_busy);
      check("rd_full", {31'd0, rd_full},
            {31'd0, (m_cnt[id_rd] == 3 && id_rd != 0)});
      check("sb_error", {31'd0, sb_error}, {31'd0, m_err});
    end
  end

  logic [4:0] q[$];
  logic [2:0] f3s [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
  localparam logic [31:0] Word = 32'h80FF7F01;

  initial begin
    idle();
    rst_n = 0;
    mem_valid = 1; mem_reg_we = 1; mem_rd = 5'd5; mem_alu_result = 32'h1234;
    tick();
    cmp_en = 1;
    tick();
    check("rst_we", {31'd0, write_enable}, 32'd0);
    check("rst_busy", busy_mask, 32'd0);
    check("rst_sberr", {31'd0, sb_error}, 32'd0);
    rst_n = 1;
    idle();

    // ALU write, then rd=0 must not write
    mem_op(5'd5, 2'd0, 3'd0, 32'hDEADBEEF, 32'd0, 32'd0);
    check("alu_we", {31'd0, write_enable}, 32'd1);
    check("alu_addr", {27'd0, addr_rd}, 32'd5);
    check("alu_data", data_rd, 32'hDEADBEEF);
    check("model_alu_data", m_data, 32'hDEADBEEF);
    mem_op(5'd0, 2'd0, 3'd0, 32'h12345678, 32'd0, 32'd0);
    check("x0_we", {31'd0, write_enable}, 32'd0);
    check("x0_hold", data_rd, 32'hDEADBEEF);

    // Loads from a fixed word
    mem_op(5'd10, 2'd1, 3'b000, 32'h1003, Word, 32'd0);
    check("lb3", data_rd, 32'hFFFFFF80);
    check("model_lb3", m_data, 32'hFFFFFF80);
    mem_op(5'd11, 2'd1, 3'b100, 32'h1003, Word, 32'd0);
    check("lbu3", data_rd, 32'h00000080);
    mem_op(5'd12, 2'd1, 3'b001, 32'h1002, Word, 32'd0);
    check("lh2", data_rd, 32'hFFFF80FF);
    check("model_lh2", m_data, 32'hFFFF80FF);
    mem_op(5'd13, 2'd1, 3'b101, 32'h1000, Word, 32'd0);
    check("lhu0", data_rd, 32'h00007F01);
    mem_op(5'd14, 2'd1, 3'b010, 32'h1001, Word, 32'd0);
    check("lw1_we", {31'd0, write_enable}, 32'd0);
    check("lw1_mis", {31'd0, load_misaligned}, 32'd1);
    tick();
    check("lw1_mis_pulse", {31'd0, load_misaligned}, 32'd0);

    // PC+4 wraps
    mem_op(5'd1, 2'd2, 3'd0, 32'd0, 32'd0, 32'hFFFFFFFC);
    check("pc4_we", {31'd0, write_enable}, 32'd1);
    check("pc4_data", data_rd, 32'h00000000);
    check("no_sberr", {31'd0, sb_error}, 32'd0);
    tick();

    // Scoreboard saturation and simultaneous inc/dec
    rst_n = 0; tick(); rst_n = 1;
    id_issue = 1; id_rd_we = 1; id_rd = 5'd7;
    tick(); tick(); tick();
    id_issue = 0; #1;
    check("sb_busy7", busy_mask, 32'h80);
    check("sb_full7", {31'd0, rd_full}, 32'd1);
    check("sb_noerr", {31'd0, sb_error}, 32'd0);
    id_issue = 1; tick(); id_issue = 0; #1;
    check("sb_overflow", {31'd0, sb_error}, 32'd1);
    mem_valid = 1; mem_reg_we = 1; mem_rd = 5'd7; mem_alu_result = 32'h77;
    tick();
    idle(); id_issue = 1; id_rd_we = 1; id_rd = 5'd7;
    tick();
    id_issue = 0; #1;
    check("sb_incdec_full", {31'd0, rd_full}, 32'd1);
    check("sb_incdec_busy", busy_mask, 32'h80);
    mem_valid = 1; mem_reg_we = 1; mem_rd = 5'd7;
    tick(); tick(); tick();
    idle(); tick();
    check("sb_drained", busy_mask, 32'd0);

    // Reset with a write in flight
    rst_n = 0; tick(); rst_n = 1;
    id_issue = 1; id_rd_we = 1; id_rd = 5'd3;
    tick(); idle(); #1;
    check("r6_busy", busy_mask, 32'h8);
    mem_valid = 1; mem_reg_we = 1; mem_rd = 5'd3; mem_alu_result = 32'h55;
    rst_n = 0;
    tick();
    rst_n = 1; idle(); #1;
    check("r6_we", {31'd0, write_enable}, 32'd0);
    check("r6_busy_clr", busy_mask, 32'd0);
    tick();
    check("r6_we_after", {31'd0, write_enable}, 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst_n = ($urandom_range(0, 199) != 0);
      if (!rst_n) q.delete();
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        mem_valid = 1; mem_reg_we = 1; mem_rd = q.pop_front();
      end else begin
        mem_valid  = 1'($urandom_range(0, 1));
        mem_reg_we = ($urandom_range(0, 15) == 0);
        mem_rd     = 5'($urandom_range(0, 31));
      end
      mem_wb_sel     = 2'($urandom_range(0, 3));
      mem_funct3     = f3s[$urandom_range(0, 5)];
      mem_alu_result = $urandom;
      mem_load_word  = $urandom;
      mem_pc         = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
      id_issue       = 1'($urandom_range(0, 1));
      id_rd_we       = 1'($urandom_range(0, 1));
      id_rd          = 5'($urandom_range(0, 31));
      if (rst_n && id_issue && id_rd_we && id_rd != 0) begin
        if (m_cnt[id_rd] < 3) q.push_back(id_rd);
        else if ($urandom_range(0, 3) != 0) id_issue = 0;
      end
      tick();
    end

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
